// File: rtl/ooo_xbar_4x4_rob8.sv
// ooo_xbar_4x4_rob8: 4x4 request/response crossbar with a reorder buffer per master,
// so each master receives read data in its own issue order even when slaves answer out of order.
module ooo_xbar_4x4_rob8 #(
   parameter int ROB_DEPTH   = 8,
   parameter int SLV_SEL_MSB = 31
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        master_0_req,
   input  logic [31:0] master_0_addr,
   input  logic        master_0_cmd,
   input  logic [31:0] master_0_wdata,
   output logic        master_0_ack,
   output logic [31:0] master_0_rdata,
   output logic        master_0_resp,
   input  logic        master_1_req,
   input  logic [31:0] master_1_addr,
   input  logic        master_1_cmd,
   input  logic [31:0] master_1_wdata,
   output logic        master_1_ack,
   output logic [31:0] master_1_rdata,
   output logic        master_1_resp,
   input  logic        master_2_req,
   input  logic [31:0] master_2_addr,
   input  logic        master_2_cmd,
   input  logic [31:0] master_2_wdata,
   output logic        master_2_ack,
   output logic [31:0] master_2_rdata,
   output logic        master_2_resp,
   input  logic        master_3_req,
   input  logic [31:0] master_3_addr,
   input  logic        master_3_cmd,
   input  logic [31:0] master_3_wdata,
   output logic        master_3_ack,
   output logic [31:0] master_3_rdata,
   output logic        master_3_resp,
   output logic        slave_0_req,
   output logic [31:0] slave_0_addr,
   output logic        slave_0_cmd,
   output logic [1:0]  slave_0_reqtid,
   output logic [31:0] slave_0_wdata,
   input  logic        slave_0_ack,
   input  logic [1:0]  slave_0_resptid,
   input  logic [31:0] slave_0_rdata,
   input  logic        slave_0_resp,
   output logic        slave_1_req,
   output logic [31:0] slave_1_addr,
   output logic        slave_1_cmd,
   output logic [1:0]  slave_1_reqtid,
   output logic [31:0] slave_1_wdata,
   input  logic        slave_1_ack,
   input  logic [1:0]  slave_1_resptid,
   input  logic [31:0] slave_1_rdata,
   input  logic        slave_1_resp,
   output logic        slave_2_req,
   output logic [31:0] slave_2_addr,
   output logic        slave_2_cmd,
   output logic [1:0]  slave_2_reqtid,
   output logic [31:0] slave_2_wdata,
   input  logic        slave_2_ack,
   input  logic [1:0]  slave_2_resptid,
   input  logic [31:0] slave_2_rdata,
   input  logic        slave_2_resp,
   output logic        slave_3_req,
   output logic [31:0] slave_3_addr,
   output logic        slave_3_cmd,
   output logic [1:0]  slave_3_reqtid,
   output logic [31:0] slave_3_wdata,
   input  logic        slave_3_ack,
   input  logic [1:0]  slave_3_resptid,
   input  logic [31:0] slave_3_rdata,
   input  logic        slave_3_resp
);
   localparam int AW = $clog2(ROB_DEPTH);
   localparam int CW = AW + 1;
   logic        m_req [4], m_cmd [4], m_ack [4], m_resp [4];
   logic [31:0] m_addr [4], m_wdata [4], m_rdata [4];
   logic        s_req [4], s_cmd [4], s_ack [4], s_resp [4];
   logic [31:0] s_addr [4], s_wdata [4], s_rdata [4];
   logic [1:0]  s_reqtid [4], s_resptid [4];
   logic [1:0]           rr [4];
   logic [CW-1:0]        head [4], tail [4], cnt [4];
   logic [ROB_DEPTH-1:0] rob_v [4];
   logic [1:0]           rob_slv [4][ROB_DEPTH];
   logic [31:0]          rob_d [4][ROB_DEPTH];
   logic [1:0]           sel [4], win [4];
   logic                 elig [4], win_v [4], mt_v [4], drain [4];
   logic [AW-1:0]        mt_idx [4];
   logic [31:0]          drain_d [4];
   assign m_req     = '{master_0_req, master_1_req, master_2_req, master_3_req};
   assign m_cmd     = '{master_0_cmd, master_1_cmd, master_2_cmd, master_3_cmd};
   assign m_addr    = '{master_0_addr, master_1_addr, master_2_addr, master_3_addr};
   assign m_wdata   = '{master_0_wdata, master_1_wdata, master_2_wdata, master_3_wdata};
   assign s_ack     = '{slave_0_ack, slave_1_ack, slave_2_ack, slave_3_ack};
   assign s_resp    = '{slave_0_resp, slave_1_resp, slave_2_resp, slave_3_resp};
   assign s_resptid = '{slave_0_resptid, slave_1_resptid, slave_2_resptid, slave_3_resptid};
   assign s_rdata   = '{slave_0_rdata, slave_1_rdata, slave_2_rdata, slave_3_rdata};
   assign {master_0_ack, master_1_ack, master_2_ack, master_3_ack}         = {m_ack[0], m_ack[1], m_ack[2], m_ack[3]};
   assign {master_0_resp, master_1_resp, master_2_resp, master_3_resp}     = {m_resp[0], m_resp[1], m_resp[2], m_resp[3]};
   assign {master_0_rdata, master_1_rdata, master_2_rdata, master_3_rdata} = {m_rdata[0], m_rdata[1], m_rdata[2], m_rdata[3]};
   assign {slave_0_req, slave_1_req, slave_2_req, slave_3_req}             = {s_req[0], s_req[1], s_req[2], s_req[3]};
   assign {slave_0_cmd, slave_1_cmd, slave_2_cmd, slave_3_cmd}             = {s_cmd[0], s_cmd[1], s_cmd[2], s_cmd[3]};
   assign {slave_0_addr, slave_1_addr, slave_2_addr, slave_3_addr}         = {s_addr[0], s_addr[1], s_addr[2], s_addr[3]};
   assign {slave_0_wdata, slave_1_wdata, slave_2_wdata, slave_3_wdata}     = {s_wdata[0], s_wdata[1], s_wdata[2], s_wdata[3]};
   assign {slave_0_reqtid, slave_1_reqtid, slave_2_reqtid, slave_3_reqtid} = {s_reqtid[0], s_reqtid[1], s_reqtid[2], s_reqtid[3]};
   // Round-robin per slave; reads are withheld from arbitration while the master's ROB is full
   always_comb begin
      logic [1:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         sel[i]  = m_addr[i][SLV_SEL_MSB -: 2];
         cnt[i]  = tail[i] - head[i];
         elig[i] = rst_i && m_req[i] && (m_cmd[i] || !cnt[i][AW]);
      end
      for (int m = 0; m < 4; m++) begin
         win_v[m] = 1'b0;
         win[m]   = '0;
         for (int k = 0; k < 4; k++) begin
            n = rr[m] + 2'(k);
            if (!win_v[m] && elig[n] && sel[n] == 2'(m)) begin
               win_v[m] = 1'b1;
               win[m]   = n;
            end
         end
      end
   end
   always_comb begin
      for (int m = 0; m < 4; m++) begin
         s_req[m]    = win_v[m];
         s_addr[m]   = m_addr[win[m]];
         s_cmd[m]    = m_cmd[win[m]];
         s_wdata[m]  = m_wdata[win[m]];
         s_reqtid[m] = win[m];
      end
      for (int n = 0; n < 4; n++)
         m_ack[n] = win_v[sel[n]] && win[sel[n]] == 2'(n) && s_ack[sel[n]];
   end
   // Each response fills the oldest pending entry from its slave; a response landing on the head drains at once
   always_comb begin
      logic [1:0]    t;
      logic [AW-1:0] idx;
      t   = '0;
      idx = '0;
      for (int m = 0; m < 4; m++) begin
         mt_v[m]   = 1'b0;
         mt_idx[m] = '0;
         t         = s_resptid[m];
         for (int k = 0; k < ROB_DEPTH; k++) begin
            idx = head[t][AW-1:0] + AW'(k);
            if (s_resp[m] && !mt_v[m] && CW'(k) < cnt[t] && rob_slv[t][idx] == 2'(m) && !rob_v[t][idx]) begin
               mt_v[m]   = 1'b1;
               mt_idx[m] = idx;
            end
         end
      end
      for (int n = 0; n < 4; n++) begin
         drain[n]   = rob_v[n][head[n][AW-1:0]];
         drain_d[n] = rob_d[n][head[n][AW-1:0]];
         for (int m = 0; m < 4; m++)
            if (mt_v[m] && s_resptid[m] == 2'(n) && mt_idx[m] == head[n][AW-1:0]) begin
               drain[n]   = 1'b1;
               drain_d[n] = s_rdata[m];
            end
      end
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < 4; i++) begin
            rr[i]      <= '0;
            head[i]    <= '0;
            tail[i]    <= '0;
            rob_v[i]   <= '0;
            m_resp[i]  <= 1'b0;
            m_rdata[i] <= '0;
         end
      end else begin
         for (int m = 0; m < 4; m++) begin
            if (win_v[m] && s_ack[m]) rr[m] <= win[m] + 2'd1;
            if (mt_v[m]) rob_v[s_resptid[m]][mt_idx[m]] <= 1'b1;
         end
         for (int n = 0; n < 4; n++) begin
            m_resp[n] <= drain[n];
            if (drain[n]) begin
               m_rdata[n]                  <= drain_d[n];
               rob_v[n][head[n][AW-1:0]]   <= 1'b0;
               head[n]                     <= head[n] + CW'(1);
            end
            if (m_ack[n] && !m_cmd[n]) tail[n] <= tail[n] + CW'(1);
         end
      end
   end
   always_ff @(posedge clk_i) begin
      for (int m = 0; m < 4; m++)
         if (mt_v[m]) rob_d[s_resptid[m]][mt_idx[m]] <= s_rdata[m];
      for (int n = 0; n < 4; n++)
         if (m_ack[n] && !m_cmd[n]) rob_slv[n][tail[n][AW-1:0]] <= sel[n];
   end
endmodule

// File: tb/tb_ooo_xbar_4x4_rob8.sv
// tb_ooo_xbar_4x4_rob8: directed scenarios plus a randomized run scored against
// per-master issue-order queues and per-slave in-order response queues.
module tb_ooo_xbar_4x4_rob8;
   typedef struct packed {logic [1:0] tid; logic [31:0] d;} rsp_t;
   logic        clk = 1'b0, rst_i;
   logic        m_req [4], m_cmd [4], m_ack [4], m_resp [4];
   logic [31:0] m_addr [4], m_wdata [4], m_rdata [4];
   logic        s_req [4], s_cmd [4], s_ack [4], s_resp [4];
   logic [31:0] s_addr [4], s_wdata [4], s_rdata [4];
   logic [1:0]  s_reqtid [4], s_resptid [4];
   int          cmp = 0, errs = 0;
   rsp_t        sq [4][$];
   logic [31:0] exq [4][$];
   always #5 clk = ~clk;
   ooo_xbar_4x4_rob8 dut (
      .clk_i(clk), .rst_i(rst_i),
      .master_0_req(m_req[0]), .master_0_addr(m_addr[0]), .master_0_cmd(m_cmd[0]), .master_0_wdata(m_wdata[0]),
      .master_0_ack(m_ack[0]), .master_0_rdata(m_rdata[0]), .master_0_resp(m_resp[0]),
      .master_1_req(m_req[1]), .master_1_addr(m_addr[1]), .master_1_cmd(m_cmd[1]), .master_1_wdata(m_wdata[1]),
      .master_1_ack(m_ack[1]), .master_1_rdata(m_rdata[1]), .master_1_resp(m_resp[1]),
      .master_2_req(m_req[2]), .master_2_addr(m_addr[2]), .master_2_cmd(m_cmd[2]), .master_2_wdata(m_wdata[2]),
      .master_2_ack(m_ack[2]), .master_2_rdata(m_rdata[2]), .master_2_resp(m_resp[2]),
      .master_3_req(m_req[3]), .master_3_addr(m_addr[3]), .master_3_cmd(m_cmd[3]), .master_3_wdata(m_wdata[3]),
      .master_3_ack(m_ack[3]), .master_3_rdata(m_rdata[3]), .master_3_resp(m_resp[3]),
      .slave_0_req(s_req[0]), .slave_0_addr(s_addr[0]), .slave_0_cmd(s_cmd[0]), .slave_0_reqtid(s_reqtid[0]),
      .slave_0_wdata(s_wdata[0]), .slave_0_ack(s_ack[0]), .slave_0_resptid(s_resptid[0]),
      .slave_0_rdata(s_rdata[0]), .slave_0_resp(s_resp[0]),
      .slave_1_req(s_req[1]), .slave_1_addr(s_addr[1]), .slave_1_cmd(s_cmd[1]), .slave_1_reqtid(s_reqtid[1]),
      .slave_1_wdata(s_wdata[1]), .slave_1_ack(s_ack[1]), .slave_1_resptid(s_resptid[1]),
      .slave_1_rdata(s_rdata[1]), .slave_1_resp(s_resp[1]),
      .slave_2_req(s_req[2]), .slave_2_addr(s_addr[2]), .slave_2_cmd(s_cmd[2]), .slave_2_reqtid(s_reqtid[2]),
      .slave_2_wdata(s_wdata[2]), .slave_2_ack(s_ack[2]), .slave_2_resptid(s_resptid[2]),
      .slave_2_rdata(s_rdata[2]), .slave_2_resp(s_resp[2]),
      .slave_3_req(s_req[3]), .slave_3_addr(s_addr[3]), .slave_3_cmd(s_cmd[3]), .slave_3_reqtid(s_reqtid[3]),
      .slave_3_wdata(s_wdata[3]), .slave_3_ack(s_ack[3]), .slave_3_resptid(s_resptid[3]),
      .slave_3_rdata(s_rdata[3]), .slave_3_resp(s_resp[3])
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) begin
         m_req[i] = 0; m_cmd[i] = 0; m_addr[i] = 0; m_wdata[i] = 0;
         s_ack[i] = 0; s_resp[i] = 0; s_resptid[i] = 0; s_rdata[i] = 0;
      end
      rst_i = 0;
      repeat (2) cyc();
      rst_i = 1;
      cyc();
   endtask

   task automatic test_reset();
      rst_i = 1;
      cyc();
      m_req[0] = 1; m_addr[0] = 32'h10; s_ack[0] = 1;
      repeat (2) cyc();
      m_req[0] = 0;
      rst_i = 0;
      m_req[0] = 1; m_cmd[0] = 0; m_addr[0] = 32'h0;
      #1;
      for (int i = 0; i < 4; i++) begin
         cmp++;
         if (m_resp[i] !== 1'b0 || m_rdata[i] !== 32'h0) begin
            errs++; $display("FAIL reset_master%0d: resp=%b rdata=%h want 0/0", i, m_resp[i], m_rdata[i]);
         end
         cmp++;
         if (s_req[i] !== 1'b0) begin errs++; $display("FAIL reset_slave_req%0d: got %b want 0", i, s_req[i]); end
      end
      cmp++;
      if (m_ack[0] !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b want 0", m_ack[0]); end
      do_reset();
   endtask

   task automatic test_single_read();
      do_reset();
      m_req[0] = 1; m_cmd[0] = 0; m_addr[0] = 32'h0000_0010; s_ack[0] = 1;
      #1;
      cmp++;
      if (s_req[0] !== 1 || s_reqtid[0] !== 2'd0 || s_addr[0] !== 32'h10 || s_cmd[0] !== 0) begin
         errs++; $display("FAIL single_fwd: req=%b tid=%0d addr=%h cmd=%b want 1/0/10/0", s_req[0], s_reqtid[0], s_addr[0], s_cmd[0]);
      end
      cmp++;
      if (m_ack[0] !== 1) begin errs++; $display("FAIL single_ack: got %b want 1", m_ack[0]); end
      cyc();
      m_req[0] = 0; s_ack[0] = 0;
      repeat (2) cyc();
      s_resp[0] = 1; s_resptid[0] = 0; s_rdata[0] = 32'h0000_0010;
      #1;
      cmp++;
      if (m_resp[0] !== 0) begin errs++; $display("FAIL single_early: resp=%b want 0", m_resp[0]); end
      cyc();
      s_resp[0] = 0;
      cmp++;
      if (m_resp[0] !== 1 || m_rdata[0] !== 32'h10) begin
         errs++; $display("FAIL single_resp: resp=%b rdata=%h want 1/00000010", m_resp[0], m_rdata[0]);
      end
      cyc();
      cmp++;
      if (m_resp[0] !== 0) begin errs++; $display("FAIL single_pulse: resp=%b want 0", m_resp[0]); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      m_req[1] = 1; m_cmd[1] = 0; m_addr[1] = 32'h8000_0000; s_ack[0] = 1; s_ack[2] = 1;
      #1;
      cmp++;
      if (m_ack[1] !== 1 || s_reqtid[2] !== 2'd1) begin errs++; $display("FAIL ooo_ack_s2: ack=%b tid=%0d want 1/1", m_ack[1], s_reqtid[2]); end
      cyc();
      m_addr[1] = 32'h0000_0004;
      #1;
      cmp++;
      if (m_ack[1] !== 1 || s_req[0] !== 1) begin errs++; $display("FAIL ooo_ack_s0: ack=%b sreq=%b want 1/1", m_ack[1], s_req[0]); end
      cyc();
      m_req[1] = 0; s_ack[0] = 0; s_ack[2] = 0;
      s_resp[0] = 1; s_resptid[0] = 1; s_rdata[0] = 32'h1;
      cyc();
      s_resp[0] = 0;
      for (int i = 0; i < 2; i++) begin
         cmp++;
         if (m_resp[1] !== 0) begin errs++; $display("FAIL ooo_hold%0d: resp=%b want 0", i, m_resp[1]); end
         cyc();
      end
      s_resp[2] = 1; s_resptid[2] = 1; s_rdata[2] = 32'h2;
      cyc();
      s_resp[2] = 0;
      cmp++;
      if (m_resp[1] !== 1 || m_rdata[1] !== 32'h2) begin errs++; $display("FAIL ooo_first: resp=%b rdata=%h want 1/2", m_resp[1], m_rdata[1]); end
      cyc();
      cmp++;
      if (m_resp[1] !== 1 || m_rdata[1] !== 32'h1) begin errs++; $display("FAIL ooo_second: resp=%b rdata=%h want 1/1", m_resp[1], m_rdata[1]); end
      cyc();
      cmp++;
      if (m_resp[1] !== 0) begin errs++; $display("FAIL ooo_end: resp=%b want 0", m_resp[1]); end
   endtask

   task automatic test_rr_writes();
      int seq [4] = '{0, 2, 0, 2};
      do_reset();
      for (int n = 0; n < 4; n++) begin
         m_req[n] = 1; m_cmd[n] = 1; m_addr[n] = 32'hC000_0000 | (n << 4); m_wdata[n] = 32'h111 * n;
      end
      s_ack[3] = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         for (int n = 0; n < 4; n++) begin
            cmp++;
            if (m_ack[n] !== (n == c)) begin errs++; $display("FAIL rr_ack c%0d m%0d: got %b want %b", c, n, m_ack[n], n == c); end
         end
         cmp++;
         if (s_wdata[3] !== 32'h111 * c) begin errs++; $display("FAIL rr_wdata c%0d: got %h want %h", c, s_wdata[3], 32'h111 * c); end
         cyc();
         m_req[c] = 0;
         for (int n = 0; n < 4; n++) begin
            cmp++;
            if (m_resp[n] !== 0) begin errs++; $display("FAIL rr_noresp m%0d: got %b want 0", n, m_resp[n]); end
         end
      end
      m_req[0] = 1; m_req[2] = 1; s_ack[3] = 0;
      for (int c = 0; c < 2; c++) begin
         #1;
         cmp++;
         if (s_reqtid[3] !== 2'd0 || m_ack[0] !== 0) begin errs++; $display("FAIL rr_noack_hold c%0d: tid=%0d ack=%b want 0/0", c, s_reqtid[3], m_ack[0]); end
         cyc();
      end
      s_ack[3] = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         cmp++;
         if (s_reqtid[3] !== 2'(seq[c])) begin errs++; $display("FAIL rr_alt c%0d: got %0d want %0d", c, s_reqtid[3], seq[c]); end
         cyc();
      end
      m_req[0] = 0; m_req[2] = 0;
   endtask

   task automatic test_rob_full();
      int acks = 0;
      do_reset();
      m_req[2] = 1; m_cmd[2] = 0; m_addr[2] = 32'h4000_0100; s_ack[1] = 1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (m_ack[2] === 1) acks++;
         cyc();
      end
      cmp++;
      if (acks != 8) begin errs++; $display("FAIL full_acks: got %0d want 8", acks); end
      s_resp[1] = 1; s_resptid[1] = 2; s_rdata[1] = 32'hF00D;
      #1;
      cmp++;
      if (m_ack[2] !== 0 || s_req[1] !== 0) begin errs++; $display("FAIL full_block: ack=%b sreq=%b want 0/0", m_ack[2], s_req[1]); end
      cyc();
      s_resp[1] = 0;
      cmp++;
      if (m_resp[2] !== 1 || m_rdata[2] !== 32'hF00D) begin errs++; $display("FAIL full_drain: resp=%b rdata=%h want 1/f00d", m_resp[2], m_rdata[2]); end
      #1;
      cmp++;
      if (m_ack[2] !== 1) begin errs++; $display("FAIL full_reack: got %b want 1", m_ack[2]); end
      cyc();
      #1;
      cmp++;
      if (m_ack[2] !== 0) begin errs++; $display("FAIL full_again: got %b want 0", m_ack[2]); end
      m_req[2] = 0;
   endtask

   task automatic test_four_same();
      do_reset();
      for (int m = 0; m < 4; m++) s_ack[m] = 1;
      for (int m = 0; m < 4; m++) begin
         m_req[3] = 1; m_cmd[3] = 0; m_addr[3] = (32'(m) << 30) | 32'h40;
         #1;
         cmp++;
         if (m_ack[3] !== 1) begin errs++; $display("FAIL four_issue%0d: ack=%b want 1", m, m_ack[3]); end
         cyc();
      end
      m_req[3] = 0;
      for (int m = 0; m < 4; m++) begin s_ack[m] = 0; s_resp[m] = 1; s_resptid[m] = 3; s_rdata[m] = 32'h100 + m; end
      cyc();
      for (int m = 0; m < 4; m++) s_resp[m] = 0;
      for (int i = 0; i < 4; i++) begin
         cmp++;
         if (m_resp[3] !== 1 || m_rdata[3] !== 32'h100 + i) begin
            errs++; $display("FAIL four_drain%0d: resp=%b rdata=%h want 1/%h", i, m_resp[3], m_rdata[3], 32'h100 + i);
         end
         cyc();
      end
      cmp++;
      if (m_resp[3] !== 0) begin errs++; $display("FAIL four_end: resp=%b want 0", m_resp[3]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_req[0] = 1; m_cmd[0] = 0; m_addr[0] = 32'h20; s_ack[0] = 1;
      repeat (5) cyc();
      m_req[0] = 0; s_ack[0] = 0;
      rst_i = 0;
      #1;
      cmp++;
      if (m_resp[0] !== 0) begin errs++; $display("FAIL mid_rst_resp: got %b want 0", m_resp[0]); end
      cyc();
      rst_i = 1;
      cyc();
      s_resp[0] = 1; s_resptid[0] = 0; s_rdata[0] = 32'hDEAD;
      cyc();
      s_resp[0] = 0;
      for (int i = 0; i < 3; i++) begin
         cmp++;
         if (m_resp[0] !== 0) begin errs++; $display("FAIL mid_stale%0d: resp=%b want 0", i, m_resp[0]); end
         cyc();
      end
      m_req[0] = 1; m_addr[0] = 32'h30; s_ack[0] = 1;
      #1;
      cmp++;
      if (m_ack[0] !== 1) begin errs++; $display("FAIL mid_newack: got %b want 1", m_ack[0]); end
      cyc();
      m_req[0] = 0; s_ack[0] = 0;
      s_resp[0] = 1; s_resptid[0] = 0; s_rdata[0] = 32'hBEEF;
      cyc();
      s_resp[0] = 0;
      cmp++;
      if (m_resp[0] !== 1 || m_rdata[0] !== 32'hBEEF) begin errs++; $display("FAIL mid_new: resp=%b rdata=%h want 1/beef", m_resp[0], m_rdata[0]); end
   endtask

   task automatic test_random();
      logic got [4];
      logic hs;
      logic [1:0] t;
      logic [31:0] e;
      rsp_t r;
      do_reset();
      for (int i = 0; i < 4; i++) begin got[i] = 0; sq[i].delete(); exq[i].delete(); end
      for (int c = 0; c < 3400; c++) begin
         for (int n = 0; n < 4; n++) begin
            if (m_resp[n]) begin
               cmp++;
               if (exq[n].size() == 0) begin errs++; $display("FAIL rnd_spurious m%0d: rdata=%h with nothing pending", n, m_rdata[n]); end
               else begin
                  e = exq[n].pop_front();
                  if (m_rdata[n] !== e) begin errs++; $display("FAIL rnd_order m%0d: got %h want %h", n, m_rdata[n], e); end
               end
            end
            cmp++;
            if (exq[n].size() > 8) begin errs++; $display("FAIL rnd_depth m%0d: %0d outstanding want <=8", n, exq[n].size()); end
            if (!m_req[n] || got[n]) begin
               m_req[n] = (c < 3000) && ($urandom_range(0, 2) != 0);
               m_cmd[n] = ($urandom_range(0, 3) == 0);
               m_addr[n] = $urandom;
               m_wdata[n] = $urandom;
            end
         end
         for (int m = 0; m < 4; m++) begin
            s_ack[m] = ($urandom_range(0, 3) != 0);
            s_resp[m] = 0;
            if (sq[m].size() > 0 && $urandom_range(0, 1) == 1) begin
               r = sq[m].pop_front();
               s_resp[m] = 1; s_resptid[m] = r.tid; s_rdata[m] = r.d;
            end
         end
         #1;
         for (int m = 0; m < 4; m++)
            if (s_req[m] && s_ack[m]) begin
               t = s_reqtid[m];
               cmp++;
               if (!m_req[t] || s_addr[m] !== m_addr[t] || s_cmd[m] !== m_cmd[t] || s_wdata[m] !== m_wdata[t] || m_addr[t][31:30] !== 2'(m)) begin
                  errs++; $display("FAIL rnd_route s%0d: tid=%0d addr=%h want addr %h", m, t, s_addr[m], m_addr[t]);
               end
               if (!s_cmd[m]) begin
                  r.tid = t; r.d = $urandom;
                  sq[m].push_back(r);
                  exq[t].push_back(r.d);
               end
            end
         for (int n = 0; n < 4; n++) begin
            hs = 0;
            for (int m = 0; m < 4; m++) if (s_req[m] && s_ack[m] && s_reqtid[m] == 2'(n)) hs = 1;
            cmp++;
            if (m_ack[n] !== hs) begin errs++; $display("FAIL rnd_ack m%0d: got %b want %b", n, m_ack[n], hs); end
            got[n] = m_ack[n];
         end
         cyc();
      end
      for (int n = 0; n < 4; n++) begin
         cmp++;
         if (exq[n].size() != 0 || sq[n].size() != 0 || m_req[n] !== 0) begin
            errs++; $display("FAIL rnd_drain %0d: exp=%0d slv=%0d req=%b want 0/0/0", n, exq[n].size(), sq[n].size(), m_req[n]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_out_of_order();
      test_rr_writes();
      test_rob_full();
      test_four_same();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule

// File: doc/ooo_xbar_4x4_rob8.md
Name: ooo_xbar_4x4_rob8

Overview:
- 4-master × 4-slave request/response crossbar.
- Slaves may return read data out of order across slaves.
- Each master port has an 8-entry reorder buffer, so every master sees read responses in its own issue order.
- Sits between the bus masters (CPU/exerciser agents) and the memory-mapped slaves; slave select is the top two address bits.

Parameters:
- ROB_DEPTH, 8, outstanding-read entries per master port (power of 2).
- SLV_SEL_MSB, 31, upper bit of the slave-select field (field is bits [SLV_SEL_MSB:SLV_SEL_MSB-1]).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- master_N_req  in  1  request valid (N=0..3).
- master_N_addr  in  32  byte address; [31:30] selects slave.
- master_N_cmd  in  1  1=write, 0=read.
- master_N_wdata  in  32  write data.
- master_N_ack  out  1  request accepted this cycle.
- master_N_rdata  out  32  read data, valid with resp.
- master_N_resp  out  1  one-cycle read-response strobe.
- slave_M_req  out  1  request to slave (M=0..3).
- slave_M_addr  out  32  forwarded master address, unmodified.
- slave_M_cmd  out  1  forwarded cmd.
- slave_M_reqtid  out  2  index of originating master.
- slave_M_wdata  out  32  forwarded wdata.
- slave_M_ack  in  1  slave accepts request.
- slave_M_resptid  in  2  master index of returned data.
- slave_M_rdata  in  32  read data.
- slave_M_resp  in  1  read-response strobe; cannot be back-pressured.

Behaviour:
- Reset (rst_i low, async): all ROBs empty, RR pointers = master 0, all master_N_resp/slave_M_req = 0, rdata = 0.
- Routing: request from master N goes to slave M = addr[31:30].
- Arbitration: per slave, round-robin among masters whose req is high and that target it.
  - Eligibility: a read is eligible only if master N's ROB is not full; writes are always eligible.
  - Pointer update: the RR pointer advances past the winner only on a handshake.
- Request path: slave_M_req/addr/cmd/wdata/reqtid are combinational from the winning master.
  - master_N_ack = granted & slave_M_ack, same cycle.
  - A transfer occurs when req & ack; masters hold request fields until ack.
- Write requests: no response is generated toward the master.
- ROB allocation: an accepted read allocates the tail entry of master N's ROB, storing the slave index M with valid=0.
- Response path:
  - slave_M_resp with resptid=N writes rdata into the oldest entry of ROB N with slave==M and valid=0, then sets valid.
  - The search runs from head, wrapping.
  - Slaves return data in order per (slave, master) pair.
  - All four slaves may respond in the same cycle, including to the same master; all writes land.
- Drain: when the ROB head entry is valid, the next rising edge registers master_N_resp=1 with its rdata and frees the head.
  - At most one response per master per cycle.
  - Minimum latency slave_M_resp → master_N_resp is 1 cycle.
- Full: with ROB_DEPTH outstanding reads, further reads from that master are not acked. Same-cycle free + allocate is allowed (count unchanged).
- Pointers: head/tail are log2(ROB_DEPTH)+1 bits, with wrap bit for full/empty.
- Protocol errors:
  - A response with no matching pending entry is dropped.
  - rst_i assertion mid-transaction discards all outstanding reads.

Test Plan:
- Reset, master 0 read addr 0x0000_0010 to slave 0, slave returns 0x0000_0010 after 3 cycles → slave_0_reqtid=0, master_0_resp one pulse, rdata=0x0000_0010, 1 cycle after slave_resp.
- Master 1 reads slave 2 then slave 0; slave 0 responds first (0x1), slave 2 second (0x2) → master_1 receives 0x2 then 0x1 only after slave 2 response.
- All four masters write slave 3 in the same cycle with slave_3_ack=1 → acks granted 0,1,2,3 over four cycles, RR order; no master_resp.
- Master 2 issues 9 reads to slave 1 with responses withheld → first 8 acked, 9th held until one response drains, then acked.
- Slaves 0–3 all assert resp with resptid=3 in one cycle for four outstanding master-3 reads → master_3_resp on four consecutive cycles in issue order.
- rst_i low while 5 reads are outstanding → ROB empties, no master_resp after release, next read completes normally.
